// File: rtl/pm_loader.sv
// ---------------------------------------------------------------------------
// pm_loader
//
// Receives a framed byte stream and writes it into program memory while
// holding the CPU core in reset. Frame layout:
//   SYNC_BYTE, LEN (0 means 256), LEN data bytes, CSUM (mod-256 sum of data)
// A good checksum releases the core (cpu_hold drops, load_done pulses); a bad
// checksum leaves the core held and raises the sticky load_err.
//
// Optional build macro: LOADER_ECHO_EN
//   Defined     - every accepted byte is echoed on tx_data/tx_valid, and the
//                 loader stops accepting bytes until the echo is taken.
//   Not defined - tx_data/tx_valid are tied to 0 and tx_ready is ignored.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   rx_data/rx_valid/
//   rx_ready              incoming byte stream (valid/ready handshake)
//   pm_wr_addr/pm_wr_data/
//   pm_wren               program-memory write port, one-cycle strobe
//   cpu_hold              held high while loading or after a failed frame
//   load_done             one-cycle pulse on a good frame
//   load_err              sticky checksum error, cleared by the next SYNC
//   bytes_written         data bytes written in the current or last frame
//   tx_data/tx_valid/
//   tx_ready              echo stream (LOADER_ECHO_EN only)
// ---------------------------------------------------------------------------
module pm_loader #(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              pm_wren,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [8:0]        bytes_written,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEN  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  logic [1:0]        state_reg;
  logic              run_reg;        // low only while in reset; gates rx_ready
  logic [ADDR_W-1:0] addr_reg;       // address the next data byte goes to
  logic [8:0]        remaining_reg;  // data bytes still expected (1..256)
  logic [7:0]        csum_reg;
  logic              pm_wren_reg;
  logic [ADDR_W-1:0] pm_wr_addr_reg;
  logic [DATA_W-1:0] pm_wr_data_reg;
  logic              cpu_hold_reg;
  logic              load_done_reg;
  logic              load_err_reg;
  logic [8:0]        bytes_written_reg;
  logic              echo_busy;
  logic              xfer;

  assign rx_ready = run_reg && !echo_busy;
  assign xfer     = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      run_reg           <= 1'b0;
      addr_reg          <= START;
      remaining_reg     <= 9'd0;
      csum_reg          <= 8'd0;
      pm_wren_reg       <= 1'b0;
      pm_wr_addr_reg    <= START;
      pm_wr_data_reg    <= '0;
      cpu_hold_reg      <= 1'b0;
      load_done_reg     <= 1'b0;
      load_err_reg      <= 1'b0;
      bytes_written_reg <= 9'd0;
    end else begin
      run_reg       <= 1'b1;
      pm_wren_reg   <= 1'b0;
      load_done_reg <= 1'b0;
      if (xfer) begin
        case (state_reg)
          ST_IDLE: begin
            // Anything other than the marker is line noise and is dropped.
            if (rx_data == SYNC_BYTE) begin
              state_reg         <= ST_LEN;
              cpu_hold_reg      <= 1'b1;
              load_err_reg      <= 1'b0;
              bytes_written_reg <= 9'd0;
              addr_reg          <= START;
              csum_reg          <= 8'd0;
            end
          end
          ST_LEN: begin
            remaining_reg <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            state_reg     <= ST_DATA;
          end
          ST_DATA: begin
            pm_wren_reg       <= 1'b1;
            pm_wr_addr_reg    <= addr_reg;
            pm_wr_data_reg    <= DATA_W'(rx_data);
            addr_reg          <= addr_reg + 1'b1;  // wraps at 2^ADDR_W
            csum_reg          <= csum_reg + rx_data;
            bytes_written_reg <= bytes_written_reg + 9'd1;
            remaining_reg     <= remaining_reg - 9'd1;
            if (remaining_reg == 9'd1)
              state_reg <= ST_CSUM;
          end
          default: begin  // ST_CSUM
            if (rx_data == csum_reg) begin
              load_done_reg <= 1'b1;
              cpu_hold_reg  <= 1'b0;
            end else begin
              load_err_reg  <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LOADER_ECHO_EN
  logic [7:0] tx_data_reg;
  logic       tx_valid_reg;

  // rx_ready is low while an echo is pending, so a new accept and an echo
  // handshake never occur in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_reg  <= 8'd0;
      tx_valid_reg <= 1'b0;
    end else if (xfer) begin
      tx_data_reg  <= rx_data;
      tx_valid_reg <= 1'b1;
    end else if (tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  assign echo_busy = tx_valid_reg;
  assign tx_data   = tx_data_reg;
  assign tx_valid  = tx_valid_reg;
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign echo_busy       = 1'b0;
  assign tx_data         = 8'd0;
  assign tx_valid        = 1'b0;
`endif

  assign pm_wren       = pm_wren_reg;
  assign pm_wr_addr    = pm_wr_addr_reg;
  assign pm_wr_data    = pm_wr_data_reg;
  assign cpu_hold      = cpu_hold_reg;
  assign load_done     = load_done_reg;
  assign load_err      = load_err_reg;
  assign bytes_written = bytes_written_reg;

endmodule

// File: tb/tb_pm_loader.sv
// ---------------------------------------------------------------------------
// tb_pm_loader
//
// Directed-vector bench for pm_loader with hand-computed expectations.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. A monitor logs every write strobe, load_done pulse and echo byte.
// ---------------------------------------------------------------------------
module tb_pm_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       pm_wren;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [8:0] bytes_written;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int tests = 0;
  int fails = 0;

  logic [15:0] wr_q[$];    // {addr, data} of each write strobe
  logic [7:0]  echo_q[$];
  int          done_cnt = 0;
  int          wr_base;
  int          done_base;

  pm_loader dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .pm_wr_addr    (pm_wr_addr),
    .pm_wr_data    (pm_wr_data),
    .pm_wren       (pm_wren),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .bytes_written (bytes_written),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_wren) wr_q.push_back({pm_wr_addr, pm_wr_data});
    if (load_done) done_cnt++;
    if (tx_valid && tx_ready) echo_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_ready_wait", int'(rx_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic mark();
    wr_base   = wr_q.size();
    done_base = done_cnt;
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr, input int data);
    if (wr_base + idx < wr_q.size())
      chk(tag, int'(wr_q[wr_base + idx]), (addr << 8) | data);
    else
      chk({tag, "_missing"}, wr_q.size(), wr_base + idx + 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rx_ready"}, int'(rx_ready), 0);
    chk({tag, "_pm_wren"}, int'(pm_wren), 0);
    chk({tag, "_pm_wr_addr"}, int'(pm_wr_addr), 0);
    chk({tag, "_pm_wr_data"}, int'(pm_wr_data), 0);
    chk({tag, "_cpu_hold"}, int'(cpu_hold), 0);
    chk({tag, "_load_done"}, int'(load_done), 0);
    chk({tag, "_load_err"}, int'(load_err), 0);
    chk({tag, "_bytes_written"}, int'(bytes_written), 0);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_rx_ready", int'(rx_ready), 1);

    // Good frame at full rate: A5 03 11 22 33 66
    mark();
    send(8'hA5);
    send(8'h03);
    chk("t1_hold_during_load", int'(cpu_hold), 1);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h66);
    idle(3);
    chk("t1_wr_count", wr_q.size() - wr_base, 3);
    chk_wr("t1_wr0", 0, 8'h00, 8'h11);
    chk_wr("t1_wr1", 1, 8'h01, 8'h22);
    chk_wr("t1_wr2", 2, 8'h02, 8'h33);
    chk("t1_done_pulses", done_cnt - done_base, 1);
    chk("t1_cpu_hold", int'(cpu_hold), 0);
    chk("t1_bytes_written", int'(bytes_written), 3);
    chk("t1_load_err", int'(load_err), 0);
`ifndef LOADER_ECHO_EN
    chk("t1_tx_valid_tied", int'(tx_valid), 0);
    chk("t1_tx_data_tied", int'(tx_data), 0);
`endif

    // Bad checksum: A5 02 10 20 31 (sum is 0x30)
    mark();
    send(8'hA5);
    send(8'h02);
    send(8'h10);
    send(8'h20);
    send(8'h31);
    idle(3);
    chk("t2_wr_count", wr_q.size() - wr_base, 2);
    chk_wr("t2_wr1", 1, 8'h01, 8'h20);
    chk("t2_done_pulses", done_cnt - done_base, 0);
    chk("t2_load_err", int'(load_err), 1);
    chk("t2_cpu_hold", int'(cpu_hold), 1);

    // Recovery frame: A5 01 07 07
    mark();
    send(8'hA5);
    chk("t2b_err_cleared_on_sync", int'(load_err), 0);
    send(8'h01);
    send(8'h07);
    send(8'h07);
    idle(3);
    chk_wr("t2b_wr0", 0, 8'h00, 8'h07);
    chk("t2b_done_pulses", done_cnt - done_base, 1);
    chk("t2b_cpu_hold", int'(cpu_hold), 0);
    chk("t2b_load_err", int'(load_err), 0);

    // Leading garbage, then SYNC used as data and as checksum: A5 01 A5 A5
    mark();
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    idle(3);
    chk("t3_garbage_no_writes", wr_q.size() - wr_base, 0);
    chk("t3_garbage_no_hold", int'(cpu_hold), 0);
    send(8'hA5);
    send(8'h01);
    send(8'hA5);
    send(8'hA5);
    idle(3);
    chk("t3_wr_count", wr_q.size() - wr_base, 1);
    chk_wr("t3_wr0", 0, 8'h00, 8'hA5);
    chk("t3_done_pulses", done_cnt - done_base, 1);
    chk("t3_bytes_written", int'(bytes_written), 1);

    // LEN=0 -> 256 bytes of 0x01, checksum 0x00
    mark();
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'h01);
    send(8'h00);
    idle(3);
    chk("t4_wr_count", wr_q.size() - wr_base, 256);
    chk_wr("t4_wr_first", 0, 8'h00, 8'h01);
    chk_wr("t4_wr_last", 255, 8'hFF, 8'h01);
    chk("t4_bytes_written", int'(bytes_written), 256);
    chk("t4_done_pulses", done_cnt - done_base, 1);
    chk("t4_cpu_hold", int'(cpu_hold), 0);

    // Reset after the 2nd data byte of A5 04 ..
    send(8'hA5);
    send(8'h04);
    send(8'h01);
    send(8'h02);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk_reset_values("t5_mid_reset");
    reset = 1'b0;
    mark();
    send(8'hA5);
    send(8'h02);
    send(8'h05);
    send(8'h06);
    send(8'h0B);
    idle(3);
    chk("t5_wr_count", wr_q.size() - wr_base, 2);
    chk_wr("t5_wr0", 0, 8'h00, 8'h05);
    chk_wr("t5_wr1", 1, 8'h01, 8'h06);
    chk("t5_done_pulses", done_cnt - done_base, 1);
    chk("t5_cpu_hold", int'(cpu_hold), 0);

`ifdef LOADER_ECHO_EN
    // Echo with the sink stalled for 5 cycles on the first echo: A5 01 09 09
    begin
      int eb;
      eb = echo_q.size();
      mark();
      tx_ready = 1'b0;
      fork
        begin
          send(8'hA5);
          send(8'h01);
          send(8'h09);
          send(8'h09);
        end
        begin
          int t;
          t = 0;
          while (!tx_valid && t < 100) begin
            @(negedge clk);
            t++;
          end
          if (t >= 100) chk("t6_tx_valid_wait", int'(tx_valid), 1);
          repeat (5) begin
            @(negedge clk);
            chk("t6_stall_rx_ready", int'(rx_ready), 0);
          end
          @(posedge clk);
          #1;
          tx_ready = 1'b1;
        end
      join
      idle(4);
      chk("t6_echo_count", echo_q.size() - eb, 4);
      if (echo_q.size() - eb >= 4) begin
        chk("t6_echo0", int'(echo_q[eb]), 8'hA5);
        chk("t6_echo1", int'(echo_q[eb + 1]), 8'h01);
        chk("t6_echo2", int'(echo_q[eb + 2]), 8'h09);
        chk("t6_echo3", int'(echo_q[eb + 3]), 8'h09);
      end
      chk_wr("t6_wr0", 0, 8'h00, 8'h09);
      chk("t6_done_pulses", done_cnt - done_base, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
Name: pm_loader

Overview:
- Writer-side counterpart to the processor's program-memory fetch path: it receives a framed byte stream and writes program memory.
- Holds the CPU core in reset while a load is in progress.
- Sits between a byte-stream source (UART receiver or test host) and the write port of program_memory.
- On a good frame, releases the core to run from address 0; on a bad frame, keeps the core held.

Parameters:
- ADDR_W, 8, program-memory address width
- DATA_W, 8, program-memory word width; stream bytes are written 1:1
- SYNC_BYTE, 8'hA5, frame start marker
- START_ADDR, 0, first program-memory address written by each frame

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming stream byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready
- pm_wr_addr  output  ADDR_W  program-memory write address
- pm_wr_data  output  DATA_W  program-memory write data
- pm_wren  output  1  one-cycle write strobe
- cpu_hold  output  1  OR'd into the processor reset; high while loading or after an error
- load_done  output  1  one-cycle pulse when a frame completes with a good checksum
- load_err  output  1  sticky; set on checksum mismatch, cleared by the next SYNC_BYTE accepted
- bytes_written  output  9  count of data bytes written in the current or last frame
- tx_data  output  8  echo byte (LOADER_ECHO_EN only; otherwise tied 0)
- tx_valid  output  1  echo valid (LOADER_ECHO_EN only; otherwise tied 0)
- tx_ready  input  1  echo sink ready (ignored without LOADER_ECHO_EN)

Behaviour:
- Reset values: state IDLE; rx_ready=0 during reset, 1 the first cycle after; pm_wren=0; pm_wr_addr=START_ADDR; pm_wr_data=0; cpu_hold=0; load_done=0; load_err=0; bytes_written=0; tx_valid=0.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CSUM.
  - LEN=0 means 256 bytes.
  - CSUM = 8-bit sum (mod 256) of the data bytes.
- States and transitions (one transfer per cycle maximum):
  - IDLE: any non-SYNC byte is discarded. On SYNC: go to LEN; cpu_hold<=1; load_err<=0; bytes_written<=0; address counter<=START_ADDR; checksum accumulator<=0.
  - LEN: latch remaining = (byte==0) ? 256 : byte; go to DATA.
  - DATA: each accepted byte produces, on the next cycle, pm_wren=1 for exactly one cycle with pm_wr_addr = current address and pm_wr_data = byte.
    - Address increments mod 2^ADDR_W (wraps silently).
    - Checksum accumulates; bytes_written increments; remaining decrements.
    - When remaining reaches 0, go to CSUM.
  - CSUM: if byte equals accumulator, pulse load_done one cycle, set cpu_hold<=0, go to IDLE. Otherwise set load_err<=1, keep cpu_hold=1, go to IDLE.
- A SYNC_BYTE value received inside LEN/DATA/CSUM is treated as ordinary data; no resync.
- rx_ready is high in every state except while an echo is pending (see optional feature).
- Write latency: strobe one cycle after acceptance. The memory write itself lands on the memory's clock edge; no read-back is performed.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. cpu_hold drops to 0 (partial image); the system controller is responsible for re-asserting reset.
- Back-to-back frames: a SYNC may be accepted in the cycle right after CSUM.
- rx_valid with rx_ready low: byte not consumed; the source must hold it.

Optional Feature:
- LOADER_ECHO_EN defined:
  - Every accepted byte (including SYNC, LEN and CSUM) is copied to tx_data, and tx_valid is set the next cycle.
  - tx_valid holds until tx_ready; transfer completes when tx_valid && tx_ready.
  - rx_ready=0 while tx_valid=1, so no byte is lost or reordered.
- Not defined: no echo; tx_data=0, tx_valid=0, tx_ready ignored, rx_ready governed only by state.

Test Plan:
- Stream A5 03 11 22 33 66 at full rate -> pm_wren at addresses 0,1,2 with data 11,22,33; load_done one pulse; cpu_hold 1→0; bytes_written=3; load_err=0.
- Stream A5 02 10 20 31 -> two writes, no load_done, load_err=1, cpu_hold stays 1; then A5 01 07 07 -> load_err clears on A5, load_done pulses, cpu_hold=0.
- Leading garbage 00 FF 5A, then A5 01 A5 A5 -> garbage ignored with no writes; one write of A5 at addr 0; good checksum.
- LEN=00 with 256 bytes of value 01, CSUM=00 -> 256 writes; address wraps FF→00; bytes_written=256; load_done.
- Assert reset after the 2nd data byte of A5 04 .. -> all outputs at reset values next cycle; a subsequent full frame loads normally.
- LOADER_ECHO_EN, tx_ready low for 5 cycles on the first echo -> rx_ready low for those cycles; echoes A5 01 09 09 emerge in order; no data lost.
